// File: rtl/ahb_slave_read.sv
// ahb_slave_read: AHB-Lite read-only slave exposing the cipher engine's
// destination/status registers and the 128-bit ciphertext FIFO head.
module ahb_slave_read #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         HSELx,
  input  logic [31:0]  HADDR,
  input  logic [1:0]   HTRANS,
  input  logic [2:0]   HBURST,
  input  logic         HWRITE,
  input  logic         HREADY,
  input  logic         fifo_empty,
  input  logic [127:0] cipher_text,
  input  logic [31:0]  destination,
  input  logic [7:0]   status,
  output logic [31:0]  HRDATA,
  output logic         read_ready,
  output logic         read_error,
  output logic         fifo_read
);

  localparam int unsigned CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] TR_SEQ = 2'd3;

  localparam logic [7:0] A_DEST   = 8'h24;
  localparam logic [7:0] A_STATUS = 8'h44;
  localparam logic [7:0] A_CT0    = 8'h48;
  localparam logic [7:0] A_CT1    = 8'h4C;
  localparam logic [7:0] A_CT2    = 8'h50;
  localparam logic [7:0] A_CT3    = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_WAIT = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        hrdata_q, hrdata_d;

  logic [7:0]         rd_addr;
  logic               map_hit;
  logic               map_cipher;
  logic [31:0]        map_word;

  // Upper address bits are not decoded.
  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:8];

  // State and datapath registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Read map decode: live address on accept, captured address while waiting.
  always_comb begin
    rd_addr    = (state_q == S_WAIT) ? addr_q : HADDR[7:0];
    map_hit    = 1'b1;
    map_cipher = 1'b0;
    map_word   = '0;
    case (rd_addr)
      A_DEST:   map_word = destination;
      A_STATUS: map_word = {24'b0, status};
      A_CT0: begin map_word = cipher_text[31:0];   map_cipher = 1'b1; end
      A_CT1: begin map_word = cipher_text[63:32];  map_cipher = 1'b1; end
      A_CT2: begin map_word = cipher_text[95:64];  map_cipher = 1'b1; end
      A_CT3: begin map_word = cipher_text[127:96]; map_cipher = 1'b1; end
      default:  map_hit = 1'b0;
    endcase
  end

  // Next-state logic; HRDATA is loaded only on the edge that enters DATA.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    hrdata_d = '0;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = S_IDLE;
        if (HREADY && HSELx && HTRANS[1]) begin
          addr_d = HADDR[7:0];
          if ((HTRANS == TR_SEQ) || (HBURST != 3'd0) || HWRITE || !map_hit) begin
            state_d = S_ERR1;
          end else if (map_cipher && fifo_empty) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            state_d  = S_DATA;
            hrdata_d = map_word;
          end
        end
      end
      S_WAIT: begin
        if (!fifo_empty) begin
          state_d  = S_DATA;
          hrdata_d = map_word;
        end else begin
          if (cnt_q != CNT_W'(WAIT_LIMIT)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(WAIT_LIMIT)) state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus response decoded from the registered state.
  always_comb begin
    read_ready = 1'b1;
    read_error = 1'b0;
    fifo_read  = 1'b0;
    case (state_q)
      S_WAIT: read_ready = 1'b0;
      S_ERR1: begin read_ready = 1'b0; read_error = 1'b1; end
      S_ERR2: read_error = 1'b1;
      S_DATA: fifo_read = (addr_q == A_CT3);
      default: ;
    endcase
  end

  assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_read.sv
// tb_ahb_slave_read: directed and randomized read transactions against a
// transaction-level model of the read map, wait and error rules.
module tb_ahb_slave_read;

  localparam int unsigned LIMIT = 16;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         HSELx;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HWRITE;
  logic         HREADY;
  logic         fifo_empty;
  logic [127:0] cipher_text;
  logic [31:0]  destination;
  logic [7:0]   status;
  logic [31:0]  HRDATA;
  logic         read_ready;
  logic         read_error;
  logic         fifo_read;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ahb_slave_read #(.WAIT_LIMIT(LIMIT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELx(HSELx), .HADDR(HADDR),
    .HTRANS(HTRANS), .HBURST(HBURST), .HWRITE(HWRITE), .HREADY(HREADY),
    .fifo_empty(fifo_empty), .cipher_text(cipher_text),
    .destination(destination), .status(status), .HRDATA(HRDATA),
    .read_ready(read_ready), .read_error(read_error), .fifo_read(fifo_read)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One response cycle: ready, error, data, pop.
  task automatic check_cycle(input string tag, input logic rdy, input logic err,
                             input logic [31:0] data, input logic pop);
    check({tag, ".ready"}, 32'(read_ready), 32'(rdy));
    check({tag, ".error"}, 32'(read_error), 32'(err));
    check({tag, ".hrdata"}, HRDATA, data);
    check({tag, ".fifo_read"}, 32'(fifo_read), 32'(pop));
  endtask

  // Reference read map.
  function automatic logic is_cipher_addr(input logic [7:0] a);
    return (a >= 8'h48) && (a <= 8'h54) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return (a == 8'h24) || (a == 8'h44) || is_cipher_addr(a);
  endfunction

  function automatic logic [31:0] model_word(input logic [7:0] a);
    int idx;
    if (a == 8'h24) return destination;
    if (a == 8'h44) return {24'b0, status};
    idx = (int'(a) - 'h48) / 4;
    return 32'(cipher_text >> (32 * idx));
  endfunction

  task automatic bus_idle();
    HSELx  = 1'b0;
    HTRANS = T_IDLE;
    HBURST = 3'd0;
    HWRITE = 1'b0;
  endtask

  task automatic randomize_sources();
    destination = $urandom;
    status      = 8'($urandom);
    cipher_text = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Drive one address phase now (overlapping the previous data phase) and
  // check the whole response; fifo_empty is held high for empty_cyc waits.
  task automatic xfer(input string tag, input logic [7:0] a, input logic [1:0] tr,
                      input logic [2:0] bu, input logic wr, input int empty_cyc);
    logic ok, ct, timed_out;
    int   waits;
    ok        = (tr == T_NONSEQ) && (bu == 3'd0) && !wr && is_mapped(a);
    ct        = ok && is_cipher_addr(a);
    timed_out = ct && (empty_cyc > int'(LIMIT));
    waits     = !ct ? 0 : (timed_out ? int'(LIMIT) : empty_cyc);
    HSELx      = 1'b1;
    HADDR      = {24'($urandom), a};
    HTRANS     = tr;
    HBURST     = bu;
    HWRITE     = wr;
    fifo_empty = (empty_cyc > 0);
    @(posedge HCLK);
    #1;
    bus_idle();
    for (int i = 1; i <= waits; i++) begin
      @(negedge HCLK);
      check_cycle($sformatf("%s.wait%0d", tag, i), 1'b0, 1'b0, 32'h0, 1'b0);
      if (i == empty_cyc) fifo_empty = 1'b0;
    end
    if (!ok || timed_out) begin
      @(negedge HCLK);
      check_cycle({tag, ".err1"}, 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge HCLK);
      check_cycle({tag, ".err2"}, 1'b1, 1'b1, 32'h0, 1'b0);
    end else begin
      @(negedge HCLK);
      check_cycle({tag, ".data"}, 1'b1, 1'b0, model_word(a), a == 8'h54);
    end
    fifo_empty = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    bus_idle();
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      check_cycle(tag, 1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  // Selected IDLE/BUSY phase: zero-wait OKAY with nothing presented.
  task automatic selected_idle(input string tag, input logic [1:0] tr);
    HSELx  = 1'b1;
    HTRANS = tr;
    HADDR  = {24'($urandom), 8'h54};
    HWRITE = 1'($urandom);
    @(posedge HCLK);
    #1;
    bus_idle();
    @(negedge HCLK);
    check_cycle(tag, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  logic [7:0] pool [12] = '{8'h24, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54,
                            8'h04, 8'h10, 8'h20, 8'h00, 8'h49, 8'hFC};

  initial begin
    logic [1:0] tr;
    logic [2:0] bu;
    logic       wr;
    int         e;

    HRESET = 1'b1;
    HREADY = 1'b1;
    HADDR  = '0;
    fifo_empty = 1'b0;
    bus_idle();
    randomize_sources();
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check_cycle("reset", 1'b1, 1'b0, 32'h0, 1'b0);

    // Status register read.
    status = 8'hA5;
    xfer("status", 8'h44, T_NONSEQ, 3'd0, 1'b0, 0);

    // Four ciphertext words back-to-back, single pop on the last.
    cipher_text = 128'h0123456789ABCDEF0123456789ABCDEF;
    xfer("ct0", 8'h48, T_NONSEQ, 3'd0, 1'b0, 0);
    xfer("ct1", 8'h4C, T_NONSEQ, 3'd0, 1'b0, 0);
    xfer("ct2", 8'h50, T_NONSEQ, 3'd0, 1'b0, 0);
    xfer("ct3", 8'h54, T_NONSEQ, 3'd0, 1'b0, 0);
    idle_cycles("idle_after_burst", 1);

    // Empty FIFO that fills after 3 cycles, and one that never fills.
    xfer("wait3", 8'h48, T_NONSEQ, 3'd0, 1'b0, 3);
    xfer("timeout", 8'h54, T_NONSEQ, 3'd0, 1'b0, 20);
    xfer("wait_limit", 8'h50, T_NONSEQ, 3'd0, 1'b0, int'(LIMIT));

    // Secret address, burst, sequential and write phases.
    xfer("key_addr", 8'h04, T_NONSEQ, 3'd0, 1'b0, 0);
    xfer("incr4", 8'h44, T_NONSEQ, 3'd3, 1'b0, 0);
    xfer("seq", 8'h24, T_SEQ, 3'd0, 1'b0, 0);
    xfer("write", 8'h24, T_NONSEQ, 3'd0, 1'b1, 0);
    selected_idle("sel_idle", T_IDLE);
    selected_idle("sel_busy", T_BUSY);

    // Reset in the 5th wait cycle, then accept on the first edge after it.
    HSELx      = 1'b1;
    HADDR      = 32'h0000_0054;
    HTRANS     = T_NONSEQ;
    fifo_empty = 1'b1;
    @(posedge HCLK);
    #1;
    bus_idle();
    for (int i = 1; i <= 5; i++) begin
      @(negedge HCLK);
      check_cycle($sformatf("rst_wait%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check_cycle("rst_abort", 1'b1, 1'b0, 32'h0, 1'b0);
    fifo_empty = 1'b0;
    xfer("post_rst", 8'h44, T_NONSEQ, 3'd0, 1'b0, 0);

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      randomize_sources();
      tr = ($urandom_range(0, 9) == 0) ? T_SEQ : T_NONSEQ;
      bu = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      wr = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      xfer($sformatf("rnd%0d", n), pool[$urandom_range(0, 11)], tr, bu, wr, e);
      case ($urandom_range(0, 5))
        0: idle_cycles($sformatf("rnd%0d.gap", n), int'($urandom_range(1, 2)));
        1: selected_idle($sformatf("rnd%0d.selidle", n), 2'($urandom_range(0, 1)));
        default: ;
      endcase
    end
    idle_cycles("final_idle", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_read.md
AHB_SLAVE_READ -- requirements
Module: ahb_slave_read

Interface
REQ-001 Parameter WAIT_LIMIT, default 16, SHALL set the maximum wait states inserted for an empty-FIFO read before an ERROR response.
REQ-002 HCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 HRESET  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 HSELx  in  1  SHALL be the slave select.
REQ-005 HADDR  in  32  SHALL be the address; only [7:0] is decoded.
REQ-006 HTRANS  in  2  SHALL be the transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-007 HBURST  in  3  SHALL be the burst type; only SINGLE=0 is supported.
REQ-008 HWRITE  in  1  SHALL be the direction; this block responds only when it is 0.
REQ-009 HREADY  in  1  SHALL be the bus ready; an address phase is sampled only when it is 1.
REQ-010 fifo_empty  in  1  SHALL indicate the output (ciphertext) FIFO is empty.
REQ-011 cipher_text  in  128  SHALL be the FIFO head word.
REQ-012 destination  in  32  SHALL be the stored destination register.
REQ-013 status  in  8  SHALL be the engine status byte.
REQ-014 HRDATA  out  32  SHALL be the registered read data.
REQ-015 read_ready  out  1  SHALL be the HREADYOUT.
REQ-016 read_error  out  1  SHALL be the HRESP (1=ERROR).
REQ-017 fifo_read  out  1  SHALL be the one-cycle FIFO pop strobe.

Function
REQ-018 A read is accepted at an edge where HSELx=1, HREADY=1, HWRITE=0 and HTRANS=NONSEQ; HADDR[7:0] is captured and the data phase starts next cycle.
REQ-019 With HSELx=1, HREADY=1 and HTRANS IDLE or BUSY, the slave SHALL give a zero-wait OKAY (read_ready=1, read_error=0) and leave all state unchanged.
REQ-020 Any accepted phase with HTRANS=SEQ, HBURST!=0, or HWRITE=1 with NONSEQ SHALL produce the ERROR response.
REQ-021 Read map: 0x24 destination; 0x44 {24'b0,status}; 0x48 cipher_text[31:0]; 0x4C [63:32]; 0x50 [95:64]; 0x54 [127:96].
REQ-022 Key/nonce addresses 0x04-0x20 are write-only secrets; reading them, or any other unmapped address, SHALL produce ERROR and HRDATA SHALL stay 0.
REQ-023 FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
REQ-024 DATA: read_ready=1, read_error=0, HRDATA holds the selected word; this is the only state in which read data is presented.
REQ-025 A ciphertext address (0x48-0x54) accepted with fifo_empty=1 SHALL go to WAIT: read_ready=0, read_error=0, wait counter incremented each cycle.
REQ-026 In WAIT, fifo_empty=0 sampled at an edge SHALL load HRDATA and enter DATA on the next cycle.
REQ-027 If the wait counter reaches WAIT_LIMIT while still empty, the FSM SHALL go to ERR1.
REQ-028 The two-cycle ERROR response SHALL be: ERR1 read_ready=0, read_error=1; then ERR2 read_ready=1, read_error=1; then IDLE, or DATA if a new phase is accepted in ERR2.
REQ-029 fifo_read SHALL pulse 1 for exactly the DATA cycle completing an 0x54 read, and never on an error or aborted transfer.
REQ-030 Back-to-back: a phase accepted during a DATA or ERR2 cycle SHALL start its own data phase next cycle with no idle gap.
REQ-031 HSELx=0 at an accept edge SHALL return the FSM to IDLE, with read_ready=1 and read_error=0.
REQ-032 Outside DATA, HRDATA SHALL be 0.
REQ-033 The wait counter is sized ceil(log2(WAIT_LIMIT+1)) bits, SHALL reset to 0 on entering WAIT, and SHALL not wrap.

Reset
REQ-034 HRESET=1 at an edge SHALL force IDLE and set HRDATA=0, read_ready=1, read_error=0, fifo_read=0, wait counter=0, captured address=0.
REQ-035 Reset during WAIT, ERR1 or DATA SHALL abandon the transfer with no fifo_read pulse; the first accept is legal on the first edge after HRESET falls.

Verification
REQ-036 Read 0x44 with status=8'hA5 -> next cycle HRDATA=32'h000000A5, read_ready=1, read_error=0.
REQ-037 FIFO head 128'h0123..CDEF, reads 0x48,0x4C,0x50,0x54 back-to-back -> 4 consecutive DATA cycles with correct words, a single fifo_read pulse on the 4th.
REQ-038 Read 0x48 with FIFO empty, fifo_empty falls after 3 cycles -> 3-4 cycles read_ready=0, then DATA with cipher_text[31:0].
REQ-039 Read 0x54 with FIFO empty for 20 cycles -> 16 waits, then ERR1 (0,1), ERR2 (1,1), no fifo_read.
REQ-040 Read 0x04, and a NONSEQ with HBURST=INCR4 -> two-cycle ERROR each, HRDATA=0.
REQ-041 HRESET=1 for one cycle in the 5th WAIT cycle -> next cycle IDLE, read_ready=1, no fifo_read, FIFO head unchanged.
